// File: rtl/vco_freq_meter_if.sv
// Result channel of the VCO frequency meter: count word plus valid/ready handshake.
interface vco_freq_meter_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic [CNT_W-1:0] freq_word;
  logic             freq_valid;
  logic             freq_sat;
  logic             freq_ready;

  // Meter side: produces the result, observes the consumer's ready
  modport master (
    output freq_word,
    output freq_valid,
    output freq_sat,
    input  freq_ready
  );

  // Consumer side: takes the result, drives ready
  modport slave (
    input  freq_word,
    input  freq_valid,
    input  freq_sat,
    output freq_ready
  );

endinterface

// File: rtl/vco_freq_meter.sv
// VCO frequency meter: counts synchronized rising edges of the VCO square wave
// over a fixed gate of clk cycles and reports the saturated count on a
// valid/ready channel, with a sticky overrun flag for unaccepted overwrites.
module vco_freq_meter #(
  parameter int unsigned GATE_CYCLES = 256,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    vco_in_i,
  input  logic                    ovr_clr_i,
  vco_freq_meter_if.master        res_if,
  output logic                    overrun_o,
  output logic                    busy_o
);

  localparam int unsigned GATE_W  = $clog2(GATE_CYCLES);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_GATE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic [GATE_W-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [CNT_W-1:0]     word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 fsat_q, fsat_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  logic                 edge_c;
  logic                 accept_c;
  logic                 load_c;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic                 sat_inc_c;

  // Synchronizer chain followed by one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vco_in_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c   = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign accept_c = valid_q & res_if.freq_ready;

  // Saturating edge count including this cycle's edge
  always_comb begin
    cnt_inc_c = cnt_q;
    sat_inc_c = sat_q;
    if (edge_c) begin
      if (cnt_q == CNT_MAX) begin
        sat_inc_c = 1'b1;
      end else begin
        cnt_inc_c = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      flush_q <= '0;
      gate_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      fsat_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      fsat_q  <= fsat_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: FLUSH primes the synchronizer, GATE counts, gate end loads result
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    word_d  = word_q;
    valid_d = valid_q;
    fsat_d  = fsat_q;
    ovr_d   = ovr_q;
    load_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = ST_GATE;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          flush_d = flush_q + FLUSH_W'(1);
        end
      end
      ST_GATE: begin
        if (gate_q == GATE_LAST) begin
          load_c = 1'b1;
          word_d = cnt_inc_c;
          fsat_d = sat_inc_c;
          gate_d = '0;
          cnt_d  = '0;
          sat_d  = 1'b0;
          // Back-to-back gates run with no flush and no gap cycle
          if (!enable_i) begin
            state_d = ST_IDLE;
          end
        end else begin
          gate_d = gate_q + GATE_W'(1);
          cnt_d  = cnt_inc_c;
          sat_d  = sat_inc_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A load always wins over a same-cycle accept
    if (load_c) begin
      valid_d = 1'b1;
    end else if (accept_c) begin
      valid_d = 1'b0;
    end

    // Overrun: new result replaces one the consumer never took; set beats clear
    if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
    if (load_c && valid_q && !res_if.freq_ready) begin
      ovr_d = 1'b1;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  assign res_if.freq_word  = word_q;
  assign res_if.freq_valid = valid_q;
  assign res_if.freq_sat   = fsat_q;
  assign overrun_o         = ovr_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_vco_freq_meter.sv
// Bench for vco_freq_meter: table of VCO waveforms with expected counts,
// plus directed sequences for latency, overrun, reset and enable corners.
module tb_vco_freq_meter;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic vco;
  logic vco6;
  logic ovr_clr;
  logic ovr_clr6;
  logic overrun, busy;
  logic overrun6, busy6;

  vco_freq_meter_if #(.CNT_W(8)) res_if ();
  vco_freq_meter_if #(.CNT_W(6)) res6_if ();

  vco_freq_meter #(.GATE_CYCLES(256), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (enable),
    .vco_in_i  (vco),
    .ovr_clr_i (ovr_clr),
    .res_if    (res_if),
    .overrun_o (overrun),
    .busy_o    (busy)
  );

  vco_freq_meter #(.GATE_CYCLES(256), .CNT_W(6), .SYNC_STAGES(2)) dut6 (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (enable),
    .vco_in_i  (vco6),
    .ovr_clr_i (ovr_clr6),
    .res_if    (res6_if),
    .overrun_o (overrun6),
    .busy_o    (busy6)
  );

  always #5 clk = ~clk;

  // VCO stimulus: 0 = constant level, 1 = divider of given period, 2 = 8-bit accumulator MSB
  int       vco_mode = 0;
  int       vco_arg  = 1;
  int       div_cnt  = 0;
  logic [7:0] acc    = 8'd0;

  initial begin
    vco  = 1'b0;
    vco6 = 1'b0;
  end

  always @(negedge clk) begin
    case (vco_mode)
      0: vco = (vco_arg != 0);
      1: begin
        div_cnt = (div_cnt + 1) % vco_arg;
        vco = (div_cnt < vco_arg / 2);
      end
      default: begin
        acc = acc + 8'(vco_arg);
        vco = acc[7];
      end
    endcase
    vco6 = ~vco6;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance negedge by negedge until freq_valid is seen or the budget runs out
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_if.freq_valid && n < limit);
  endtask

  typedef struct {
    int mode;
    int arg;
    int lo;
    int hi;
    int sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    vecs[0] = '{1, 4,   64,  64,  0};
    vecs[1] = '{1, 8,   32,  32,  0};
    vecs[2] = '{1, 2,   128, 128, 0};
    vecs[3] = '{2, 37,  36,  38,  0};
    vecs[4] = '{2, 100, 99,  101, 0};
    vecs[5] = '{2, 1,   0,   2,   0};
    vecs[6] = '{1, 6,   42,  43,  0};
    vecs[7] = '{0, 0,   0,   0,   0};

    reset              = 1'b1;
    enable             = 1'b0;
    ovr_clr            = 1'b0;
    ovr_clr6           = 1'b0;
    res_if.freq_ready  = 1'b1;
    res6_if.freq_ready = 1'b1;
    vco_mode           = 0;
    vco_arg            = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_word",    int'(res_if.freq_word), 0, 0);
    check("rst_valid",   int'(res_if.freq_valid), 0, 0);
    check("rst_sat",     int'(res_if.freq_sat), 0, 0);
    check("rst_overrun", int'(overrun), 0, 0);
    check("rst_busy",    int'(busy), 0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0, 0);

    // First-result latency with vco held high; saturating 6-bit meter alongside
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 100) check("gate_busy", int'(busy), 1, 1);
    end while (!res_if.freq_valid && n < 400);
    check("first_latency", n, 260, 260);
    check("first_word",    int'(res_if.freq_word), 0, 0);
    check("first_sat",     int'(res_if.freq_sat), 0, 0);
    check("sat6_valid",    int'(res6_if.freq_valid), 1, 1);
    check("sat6_word",     int'(res6_if.freq_word), 63, 63);
    check("sat6_sat",      int'(res6_if.freq_sat), 1, 1);

    // Table-driven waveforms, continuous gates, consumer always ready
    for (int i = 0; i < 8; i++) begin
      vco_mode = vecs[i].mode;
      vco_arg  = vecs[i].arg;
      wait_valid(400, n);
      check($sformatf("vec%0d_settle", i), int'(res_if.freq_valid), 1, 1);
      wait_valid(400, n);
      check($sformatf("vec%0d_gap", i),     n, 256, 256);
      check($sformatf("vec%0d_word", i),    int'(res_if.freq_word), vecs[i].lo, vecs[i].hi);
      check($sformatf("vec%0d_sat", i),     int'(res_if.freq_sat), vecs[i].sat, vecs[i].sat);
      check($sformatf("vec%0d_overrun", i), int'(overrun), 0, 0);
    end

    // Overrun: result left pending across a second gate end
    @(negedge clk);
    res_if.freq_ready = 1'b0;
    vco_mode = 1;
    vco_arg  = 4;
    wait_valid(400, n);
    check("ovr_first_cycles", n, 255, 255);
    check("ovr_first_flag",   int'(overrun), 0, 0);
    vco_arg = 8;
    repeat (256) @(negedge clk);
    check("ovr_valid", int'(res_if.freq_valid), 1, 1);
    check("ovr_word",  int'(res_if.freq_word), 31, 33);
    check("ovr_set",   int'(overrun), 1, 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr", int'(overrun), 0, 0);
    check("ovr_hold_valid", int'(res_if.freq_valid), 1, 1);

    // Load coinciding with accept: valid stays, no overrun
    repeat (254) @(negedge clk);
    res_if.freq_ready = 1'b1;
    @(negedge clk);
    check("coinc_valid",   int'(res_if.freq_valid), 1, 1);
    check("coinc_overrun", int'(overrun), 0, 0);
    check("coinc_word",    int'(res_if.freq_word), 32, 32);
    @(negedge clk);
    check("coinc_accepted", int'(res_if.freq_valid), 0, 0);

    // Reset in the middle of a gate clears everything at once
    repeat (98) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_word",    int'(res_if.freq_word), 0, 0);
    check("midrst_valid",   int'(res_if.freq_valid), 0, 0);
    check("midrst_sat",     int'(res_if.freq_sat), 0, 0);
    check("midrst_overrun", int'(overrun), 0, 0);
    check("midrst_busy",    int'(busy), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(400, n);
    check("rerun_latency", n, 260, 260);
    check("rerun_word",    int'(res_if.freq_word), 32, 32);

    // enable dropped mid-gate: that gate still reports, then idle
    repeat (50) @(negedge clk);
    enable = 1'b0;
    wait_valid(400, n);
    check("drop_cycles", n, 206, 206);
    check("drop_word",   int'(res_if.freq_word), 32, 32);
    check("drop_busy",   int'(busy), 0, 0);
    @(negedge clk);
    wait_valid(300, n);
    check("idle_no_result", int'(res_if.freq_valid), 0, 0);
    check("idle_busy_low",  int'(busy), 0, 0);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_busy", int'(busy), 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vco_freq_meter.md
Name: vco_freq_meter

Overview:
- Receive-side counterpart of the VCO: measures the VCO output square wave and recovers the 8-bit control word that produced it.
- Counts rising edges of the VCO output (phase-accumulator MSB) over a fixed gate of clk cycles.
- Presents each count as a result word on a valid/ready handshake.
- Sits beside the VCO in the bench and in closed-loop tuning logic (frequency readback for calibration).

Parameters:
- GATE_CYCLES, 256: length of the measurement window in clk cycles, ≥ 4.
- CNT_W, 8: result width; the count saturates at 2^CNT_W-1.
- SYNC_STAGES, 2: synchronizer flops on vco_in, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  1 = run back-to-back gates; 0 = stop after the current gate.
- vco_in  in  1  VCO square wave (VCO data_out MSB); may be asynchronous to clk.
- freq_ready  in  1  consumer accepts the result when freq_ready and freq_valid are both 1.
- ovr_clr  in  1  synchronous clear of the overrun flag.
- freq_word  out  CNT_W  last completed count, saturated.
- freq_valid  out  1  result pending.
- freq_sat  out  1  freq_word was clipped; qualified by freq_valid.
- overrun  out  1  sticky: a result was overwritten before it was accepted.
- busy  out  1  1 in the FLUSH or GATE state.

Behaviour:
- Reset values: freq_word=0, freq_valid=0, freq_sat=0, overrun=0, busy=0. Synchronizer and edge flops = 0. State = IDLE.
- Input path: SYNC_STAGES flops, then one history flop. A rising edge is sync_out=1 and hist=0. The result is not defined for vco_in toggling faster than clk/2.
- IDLE: busy=0. Moves to FLUSH when enable=1.
- FLUSH: lasts SYNC_STAGES+1 cycles and counts nothing; this primes the pipeline so stale edges are dropped. Then moves to GATE with the gate counter=0 and the edge counter=0.
- GATE: lasts exactly GATE_CYCLES cycles. Each detected edge increments the edge counter, which stops at 2^CNT_W-1 and sets an internal sat bit.
- Gate end: on the last GATE cycle, the result (including any edge detected that cycle) loads on the next edge:
  - freq_word = count, freq_sat = sat, freq_valid = 1.
  - If enable=1, the next GATE starts the following cycle with no FLUSH and no gap cycle.
  - If enable=0, go to IDLE.
- Latency: the first freq_valid asserts SYNC_STAGES+1+GATE_CYCLES+1 cycles after enable is sampled high in IDLE.
- Handshake: freq_valid holds until freq_valid and freq_ready are both 1; it clears the next cycle. freq_word and freq_sat are stable while freq_valid=1 unless a new load occurs.
- Load and accept in the same cycle: the load wins, freq_valid stays 1, and overrun is not set.
- Load while freq_valid=1 and not accepted: overwrite the result and set overrun=1.
- overrun stays set until ovr_clr=1 or reset. If ovr_clr and a new overrun occur in the same cycle, the set wins.
- enable dropping mid-gate: the current gate completes and its result is reported. enable rising again while in IDLE re-enters FLUSH.
- Reset mid-gate: all state clears immediately and the partial count is discarded.
- Recovered control word: with GATE_CYCLES=256 and the VCO's 8-bit accumulator, freq_word = data_in ±1 (phase alignment).

Test Plan:
1. Reset, then enable=1 with vco_in held at 1 → first freq_valid at cycle SYNC_STAGES+GATE_CYCLES+2 = 260; freq_word=0, freq_sat=0.
2. vco_in period 4 clk (2 high, 2 low), GATE_CYCLES=256, freq_ready=1 → every result is 64, one per 256 cycles, with no gap; overrun stays 0.
3. VCO driven with data_in=37 (then 100) feeding vco_in → freq_word ∈ {36,37,38} (then {99,100,101}).
4. CNT_W=6, vco_in period 2 → freq_word=63, freq_sat=1.
5. freq_ready=0 across two gate ends → second result overwrites the first and overrun=1; ovr_clr pulse → overrun=0. A load coinciding with an accept → overrun stays 0.
6. reset asserted at gate cycle 100 → all outputs 0 on the same cycle. Re-enable → full FLUSH+GATE latency and a correct count. enable dropped mid-gate → that result is reported, then busy=0.
